branch_rs: RTL and testbench
============================

# branch_rs

Reservation station for branch and jump micro-ops (BEQ..BGEU, JAL, JALR), sitting directly upstream of the combinational branch unit. It accepts dispatched branch ops with their prediction info and captures operand values at dispatch or from the CDB. It selects the oldest ready entry and drives it through a one-cycle issue register into the branch unit. On a flush it discards every entry younger than the flushing ROB tag.

## Interface
- DATA_WIDTH, 32, operand/PC width
- ROB_WIDTH, 4, ROB tag width
- PREG_WIDTH, 7, physical register tag width
- DEPTH, 4, entries (2..16)

- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_disp_valid  in  1  dispatch request
- o_disp_ready  out  1  space available
- i_disp_alu_op  in  4  branch op: 1000 JAL, 1001 JALR, else funct3 in [2:0]
- i_disp_pc, i_disp_imm  in  DATA_WIDTH  PC, sign-extended immediate
- i_disp_rob_tag  in  ROB_WIDTH;  i_disp_prd  in  PREG_WIDTH
- i_disp_prs1, i_disp_prs2  in  PREG_WIDTH  source tags
- i_disp_rdy1, i_disp_rdy2  in  1  source value valid at dispatch
- i_disp_val1, i_disp_val2  in  DATA_WIDTH  source values (used if rdy)
- i_disp_pred_taken  in  1;  i_disp_pred_target  in  DATA_WIDTH
- i_cdb_valid  in  1;  i_cdb_prd  in  PREG_WIDTH;  i_cdb_data  in  DATA_WIDTH
- i_flush  in  1  flush younger-than-tag
- i_flush_rob_tag  in  ROB_WIDTH  flushing op (itself kept)
- i_rob_head  in  ROB_WIDTH  oldest ROB tag, for age compare
- o_iss_valid  out  1;  o_iss_op1, o_iss_op2, o_iss_pc, o_iss_imm, o_iss_pred_target  out  DATA_WIDTH
- o_iss_alu_op  out  4;  o_iss_rob_tag  out  ROB_WIDTH;  o_iss_prd  out  PREG_WIDTH;  o_iss_pred_taken  out  1

## Operation
- Collapsing queue: entry 0 is oldest; valid entries occupy 0..count-1 contiguously.
- Dispatch is accepted when i_disp_valid && o_disp_ready. o_disp_ready = (count < DEPTH), from registered count only.
- Dispatch snoop: if a source is not ready and i_cdb_valid with i_cdb_prd == prs in the same cycle, store it as ready with i_cdb_data.
- Wakeup: every valid entry with a non-ready source matching the CDB tag captures i_cdb_data and sets ready at the edge.
- Select: lowest-index entry with both sources ready. That entry is removed and loaded into the issue register. Entries above it shift down one.
- A simultaneous dispatch writes at index count-(issued?1:0).
- Issue register: o_iss_valid is high for exactly one cycle per selected op and is low if nothing is selected. No backpressure.
- Age: age(t) = (t - i_rob_head) mod 2^ROB_WIDTH. An entry is younger when age(tag) > age(i_flush_rob_tag).
- Flush (priority over everything):
  - Younger entries are invalidated and the survivors are compacted, preserving order.
  - Dispatch in the flush cycle is dropped.
  - A selected op that is younger is not issued.
  - An already-registered o_iss_* is not retracted.
- No JAL special-casing: the op is ready when both rdy bits are set; dispatch marks unused sources ready.

## Timing
- Reset values: count 0, all entries invalid, o_iss_valid 0, all o_iss_* 0, o_disp_ready 1.
- Dispatch at edge E0 with both sources ready gives o_iss_valid in the cycle after E1, a 2-edge latency.
- CDB wakeup at edge Ek allows issue after Ek+1.
- Full with issue in the same cycle: o_disp_ready stays 0 that cycle, with no same-cycle refill.
- Reset mid-operation clears all state immediately (async). Outputs return to their reset values.

## Configuration
- BRANCH_RS_INORDER_EN
  - Defined: select considers entry 0 only, so branches issue in program order.
  - Undefined: oldest-ready selection as above.

## Structure
- Package branch_rs_pkg:
  - typedef br_rs_entry_t (valid, alu_op, pc, imm, rob_tag, prd, prs1/2, rdy1/2, val1/2, pred_taken, pred_target)
  - op constants OP_JAL=4'b1000, OP_JALR=4'b1001
- Sub-module rob_age_cmp: combinational, (tag, ref, head) -> younger flag. Instantiated once per entry plus once for the select.

## Test plan
- Reset, then dispatch BEQ (pc 0x100, rdy1=rdy2=1, val 5/5) at E0 -> o_iss_valid in the cycle after E1, op1=op2=5, pc=0x100, then low.
- Dispatch BNE with prs1=12 not ready; CDB prd=12, data=0x7 two cycles later -> issue the cycle after the following edge with op1=0x7.
- Fill 4 entries, none ready -> o_disp_ready=0. Wake entry 2 -> it issues, entries 3 shift to 2, ready returns to 1.
- Entries tags 3,4,5,6, head=2, flush tag 4 -> entries 5,6 removed, count=2; dispatch in the flush cycle ignored.
- Wrap-around: head=14, entries 15,0,1, flush tag 15 -> 0,1 removed, 15 kept.
- With BRANCH_RS_INORDER_EN: entry 0 not ready, entry 1 ready -> no issue until entry 0 wakes, then 0 then 1 in consecutive cycles.

Source files
------------

// File: rtl/branch_rs_pkg.sv
// Shared types for the branch reservation station: entry layout, issue payload, jump opcodes.
package branch_rs_pkg;

    localparam int BR_DATA_W = 32;
    localparam int BR_ROB_W  = 4;
    localparam int BR_PREG_W = 7;

    localparam logic [3:0] OP_JAL  = 4'b1000;
    localparam logic [3:0] OP_JALR = 4'b1001;

    typedef struct packed {
        logic                 valid;
        logic [3:0]           alu_op;
        logic [BR_DATA_W-1:0] pc;
        logic [BR_DATA_W-1:0] imm;
        logic [BR_ROB_W-1:0]  rob_tag;
        logic [BR_PREG_W-1:0] prd;
        logic [BR_PREG_W-1:0] prs1;
        logic [BR_PREG_W-1:0] prs2;
        logic                 rdy1;
        logic                 rdy2;
        logic [BR_DATA_W-1:0] val1;
        logic [BR_DATA_W-1:0] val2;
        logic                 pred_taken;
        logic [BR_DATA_W-1:0] pred_target;
    } br_rs_entry_t;

    typedef struct packed {
        logic [3:0]           alu_op;
        logic [BR_DATA_W-1:0] pc;
        logic [BR_DATA_W-1:0] imm;
        logic [BR_ROB_W-1:0]  rob_tag;
        logic [BR_PREG_W-1:0] prd;
        logic [BR_DATA_W-1:0] op1;
        logic [BR_DATA_W-1:0] op2;
        logic                 pred_taken;
        logic [BR_DATA_W-1:0] pred_target;
    } br_iss_t;

endpackage

// File: rtl/branch_rs_rob_age_cmp.sv
// ROB age compare: flags tag as younger than ref_tag, both measured from the ROB head.
module rob_age_cmp #(
    parameter int W = 4
) (
    input  logic [W-1:0] tag,
    input  logic [W-1:0] ref_tag,
    input  logic [W-1:0] head,
    output logic         younger
);
    logic [W-1:0] age_tag, age_ref;

    assign age_tag = tag - head;
    assign age_ref = ref_tag - head;
    assign younger = age_tag > age_ref;
endmodule

// File: rtl/branch_rs.sv
// Collapsing-queue reservation station feeding the branch unit through a one-cycle issue register.
// Optional BRANCH_RS_INORDER_EN: only the oldest entry may be selected (program-order issue).
module branch_rs
    import branch_rs_pkg::*;
#(
    parameter int DATA_WIDTH = BR_DATA_W,
    parameter int ROB_WIDTH  = BR_ROB_W,
    parameter int PREG_WIDTH = BR_PREG_W,
    parameter int DEPTH      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_disp_valid,
    output logic                  o_disp_ready,
    input  logic [3:0]            i_disp_alu_op,
    input  logic [DATA_WIDTH-1:0] i_disp_pc,
    input  logic [DATA_WIDTH-1:0] i_disp_imm,
    input  logic [ROB_WIDTH-1:0]  i_disp_rob_tag,
    input  logic [PREG_WIDTH-1:0] i_disp_prd,
    input  logic [PREG_WIDTH-1:0] i_disp_prs1,
    input  logic [PREG_WIDTH-1:0] i_disp_prs2,
    input  logic                  i_disp_rdy1,
    input  logic                  i_disp_rdy2,
    input  logic [DATA_WIDTH-1:0] i_disp_val1,
    input  logic [DATA_WIDTH-1:0] i_disp_val2,
    input  logic                  i_disp_pred_taken,
    input  logic [DATA_WIDTH-1:0] i_disp_pred_target,
    input  logic                  i_cdb_valid,
    input  logic [PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    input  logic                  i_flush,
    input  logic [ROB_WIDTH-1:0]  i_flush_rob_tag,
    input  logic [ROB_WIDTH-1:0]  i_rob_head,
    output logic                  o_iss_valid,
    output logic [DATA_WIDTH-1:0] o_iss_op1,
    output logic [DATA_WIDTH-1:0] o_iss_op2,
    output logic [DATA_WIDTH-1:0] o_iss_pc,
    output logic [DATA_WIDTH-1:0] o_iss_imm,
    output logic [DATA_WIDTH-1:0] o_iss_pred_target,
    output logic [3:0]            o_iss_alu_op,
    output logic [ROB_WIDTH-1:0]  o_iss_rob_tag,
    output logic [PREG_WIDTH-1:0] o_iss_prd,
    output logic                  o_iss_pred_taken
);
    localparam int CW = $clog2(DEPTH + 1);

    br_rs_entry_t     ent      [DEPTH];
    br_rs_entry_t     ent_woke [DEPTH];
    br_rs_entry_t     ent_nxt  [DEPTH];
    br_rs_entry_t     disp_ent;
    br_iss_t          sel_iss, iss_q;
    logic [CW-1:0]    count, count_nxt, kept_cnt;
    logic [CW-1:0]    pos [DEPTH];
    logic [DEPTH-1:0] younger, can_sel, sel_oh, keep;
    logic             sel_any, sel_younger, iss_fire, disp_fire, iss_valid_q;

    assign o_disp_ready = (count < CW'(DEPTH));
    assign disp_fire    = i_disp_valid && o_disp_ready && !i_flush;

    // A source that is not ready at dispatch can still catch the CDB broadcast of that same cycle.
    always_comb begin
        disp_ent             = '0;
        disp_ent.valid       = 1'b1;
        disp_ent.alu_op      = i_disp_alu_op;
        disp_ent.pc          = i_disp_pc;
        disp_ent.imm         = i_disp_imm;
        disp_ent.rob_tag     = i_disp_rob_tag;
        disp_ent.prd         = i_disp_prd;
        disp_ent.prs1        = i_disp_prs1;
        disp_ent.prs2        = i_disp_prs2;
        disp_ent.rdy1        = i_disp_rdy1 || (i_cdb_valid && i_cdb_prd == i_disp_prs1);
        disp_ent.rdy2        = i_disp_rdy2 || (i_cdb_valid && i_cdb_prd == i_disp_prs2);
        disp_ent.val1        = i_disp_rdy1 ? i_disp_val1 : i_cdb_data;
        disp_ent.val2        = i_disp_rdy2 ? i_disp_val2 : i_cdb_data;
        disp_ent.pred_taken  = i_disp_pred_taken;
        disp_ent.pred_target = i_disp_pred_target;
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_age
        rob_age_cmp #(.W(ROB_WIDTH)) u_age (
            .tag(ent[g].rob_tag), .ref_tag(i_flush_rob_tag), .head(i_rob_head), .younger(younger[g])
        );
    end

    // Select sees registered ready bits; CDB wakeup lands at the edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_woke[i] = ent[i];
            if (i_cdb_valid && ent[i].valid && !ent[i].rdy1 && ent[i].prs1 == i_cdb_prd) begin
                ent_woke[i].rdy1 = 1'b1;
                ent_woke[i].val1 = i_cdb_data;
            end
            if (i_cdb_valid && ent[i].valid && !ent[i].rdy2 && ent[i].prs2 == i_cdb_prd) begin
                ent_woke[i].rdy2 = 1'b1;
                ent_woke[i].val2 = i_cdb_data;
            end
            can_sel[i] = ent[i].valid && ent[i].rdy1 && ent[i].rdy2;
`ifdef BRANCH_RS_INORDER_EN
            if (i != 0) can_sel[i] = 1'b0;
`endif
        end
    end

    always_comb begin
        sel_any = 1'b0;
        sel_oh  = '0;
        sel_iss = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (can_sel[i] && !sel_any) begin
                sel_any             = 1'b1;
                sel_oh[i]           = 1'b1;
                sel_iss.alu_op      = ent[i].alu_op;
                sel_iss.pc          = ent[i].pc;
                sel_iss.imm         = ent[i].imm;
                sel_iss.rob_tag     = ent[i].rob_tag;
                sel_iss.prd         = ent[i].prd;
                sel_iss.op1         = ent[i].val1;
                sel_iss.op2         = ent[i].val2;
                sel_iss.pred_taken  = ent[i].pred_taken;
                sel_iss.pred_target = ent[i].pred_target;
            end
        end
    end

    rob_age_cmp #(.W(ROB_WIDTH)) u_sel_age (
        .tag(sel_iss.rob_tag), .ref_tag(i_flush_rob_tag), .head(i_rob_head), .younger(sel_younger)
    );

    assign iss_fire = sel_any && !(i_flush && sel_younger);

    // Survivors (not selected, not flushed) compact downward; pos is each survivor's new slot.
    always_comb begin
        keep     = '0;
        kept_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pos[i]   = kept_cnt;
            keep[i]  = ent[i].valid && !sel_oh[i] && !(i_flush && younger[i]);
            kept_cnt = kept_cnt + CW'(keep[i]);
        end
    end

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            ent_nxt[j] = '0;
            for (int i = j; i < DEPTH; i++)
                if (keep[i] && pos[i] == CW'(j)) ent_nxt[j] = ent_woke[i];
            if (disp_fire && kept_cnt == CW'(j)) ent_nxt[j] = disp_ent;
        end
    end

    assign count_nxt = kept_cnt + CW'(disp_fire);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count       <= '0;
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
        end else begin
            count       <= count_nxt;
            iss_valid_q <= iss_fire;
            if (iss_fire) iss_q <= sel_iss;
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
        end
    end

    assign o_iss_valid       = iss_valid_q;
    assign o_iss_op1         = iss_q.op1;
    assign o_iss_op2         = iss_q.op2;
    assign o_iss_pc          = iss_q.pc;
    assign o_iss_imm         = iss_q.imm;
    assign o_iss_pred_target = iss_q.pred_target;
    assign o_iss_alu_op      = iss_q.alu_op;
    assign o_iss_rob_tag     = iss_q.rob_tag;
    assign o_iss_prd         = iss_q.prd;
    assign o_iss_pred_taken  = iss_q.pred_taken;
endmodule

// File: tb/tb_branch_rs.sv
// Bench for branch_rs: directed scenarios plus random traffic against a queue-based reference model.
module tb_branch_rs;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_disp_valid;
    logic        o_disp_ready;
    logic [3:0]  i_disp_alu_op;
    logic [31:0] i_disp_pc, i_disp_imm;
    logic [3:0]  i_disp_rob_tag;
    logic [6:0]  i_disp_prd, i_disp_prs1, i_disp_prs2;
    logic        i_disp_rdy1, i_disp_rdy2;
    logic [31:0] i_disp_val1, i_disp_val2;
    logic        i_disp_pred_taken;
    logic [31:0] i_disp_pred_target;
    logic        i_cdb_valid;
    logic [6:0]  i_cdb_prd;
    logic [31:0] i_cdb_data;
    logic        i_flush;
    logic [3:0]  i_flush_rob_tag, i_rob_head;
    logic        o_iss_valid;
    logic [31:0] o_iss_op1, o_iss_op2, o_iss_pc, o_iss_imm, o_iss_pred_target;
    logic [3:0]  o_iss_alu_op;
    logic [3:0]  o_iss_rob_tag;
    logic [6:0]  o_iss_prd;
    logic        o_iss_pred_taken;

    always #5 clk = ~clk;

    branch_rs #(.DATA_WIDTH(32), .ROB_WIDTH(4), .PREG_WIDTH(7), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_disp_valid(i_disp_valid), .o_disp_ready(o_disp_ready),
        .i_disp_alu_op(i_disp_alu_op), .i_disp_pc(i_disp_pc), .i_disp_imm(i_disp_imm),
        .i_disp_rob_tag(i_disp_rob_tag), .i_disp_prd(i_disp_prd),
        .i_disp_prs1(i_disp_prs1), .i_disp_prs2(i_disp_prs2),
        .i_disp_rdy1(i_disp_rdy1), .i_disp_rdy2(i_disp_rdy2),
        .i_disp_val1(i_disp_val1), .i_disp_val2(i_disp_val2),
        .i_disp_pred_taken(i_disp_pred_taken), .i_disp_pred_target(i_disp_pred_target),
        .i_cdb_valid(i_cdb_valid), .i_cdb_prd(i_cdb_prd), .i_cdb_data(i_cdb_data),
        .i_flush(i_flush), .i_flush_rob_tag(i_flush_rob_tag), .i_rob_head(i_rob_head),
        .o_iss_valid(o_iss_valid), .o_iss_op1(o_iss_op1), .o_iss_op2(o_iss_op2),
        .o_iss_pc(o_iss_pc), .o_iss_imm(o_iss_imm), .o_iss_pred_target(o_iss_pred_target),
        .o_iss_alu_op(o_iss_alu_op), .o_iss_rob_tag(o_iss_rob_tag), .o_iss_prd(o_iss_prd),
        .o_iss_pred_taken(o_iss_pred_taken)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] pc, imm;
        logic [3:0]  tag;
        logic [6:0]  prd, s1, s2;
        bit          r1, r2;
        logic [31:0] v1, v2;
        bit          pt;
        logic [31:0] ptgt;
    } m_ent_t;

    m_ent_t mq[$];
    m_ent_t m_iss;
    bit     m_iss_valid;
    int     n_chk = 0;
    int     n_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_younger(logic [3:0] t);
        int at, af;
        at = (int'(t) - int'(i_rob_head) + 16) % 16;
        af = (int'(i_flush_rob_tag) - int'(i_rob_head) + 16) % 16;
        return at > af;
    endfunction

    function automatic void m_reset();
        mq.delete();
        m_iss       = '{default: '0};
        m_iss_valid = 1'b0;
    endfunction

    // One clock of the station: oldest-ready pick, CDB capture, flush filter, dispatch append.
    function automatic void model_step();
        int     sel, lim;
        bit     fire, acc;
        m_ent_t s, e;
        m_ent_t kq[$];
        sel = -1;
        lim = mq.size();
`ifdef BRANCH_RS_INORDER_EN
        if (lim > 1) lim = 1;
`endif
        for (int i = 0; i < lim; i++)
            if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
        acc  = i_disp_valid && (mq.size() < DEPTH) && !i_flush;
        fire = 1'b0;
        s    = '{default: '0};
        if (sel >= 0) begin
            s    = mq[sel];
            fire = !(i_flush && m_younger(s.tag));
            mq.delete(sel);
        end
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (i_cdb_valid && !e.r1 && e.s1 == i_cdb_prd) begin e.r1 = 1; e.v1 = i_cdb_data; end
            if (i_cdb_valid && !e.r2 && e.s2 == i_cdb_prd) begin e.r2 = 1; e.v2 = i_cdb_data; end
            mq[i] = e;
        end
        if (i_flush) begin
            for (int i = 0; i < mq.size(); i++)
                if (!m_younger(mq[i].tag)) kq.push_back(mq[i]);
            mq = kq;
        end
        if (acc) begin
            e.op = i_disp_alu_op; e.pc = i_disp_pc; e.imm = i_disp_imm; e.tag = i_disp_rob_tag;
            e.prd = i_disp_prd; e.s1 = i_disp_prs1; e.s2 = i_disp_prs2;
            e.pt = i_disp_pred_taken; e.ptgt = i_disp_pred_target;
            e.r1 = i_disp_rdy1 || (i_cdb_valid && i_cdb_prd == i_disp_prs1);
            e.r2 = i_disp_rdy2 || (i_cdb_valid && i_cdb_prd == i_disp_prs2);
            e.v1 = i_disp_rdy1 ? i_disp_val1 : i_cdb_data;
            e.v2 = i_disp_rdy2 ? i_disp_val2 : i_cdb_data;
            mq.push_back(e);
        end
        m_iss_valid = fire;
        if (fire) m_iss = s;
    endfunction

    task automatic check_outputs();
        chk("disp_ready", 32'(o_disp_ready), 32'(mq.size() < DEPTH));
        chk("iss_valid", 32'(o_iss_valid), 32'(m_iss_valid));
        chk("iss_op1", o_iss_op1, m_iss.v1);
        chk("iss_op2", o_iss_op2, m_iss.v2);
        chk("iss_pc", o_iss_pc, m_iss.pc);
        chk("iss_imm", o_iss_imm, m_iss.imm);
        chk("iss_alu_op", 32'(o_iss_alu_op), 32'(m_iss.op));
        chk("iss_rob_tag", 32'(o_iss_rob_tag), 32'(m_iss.tag));
        chk("iss_prd", 32'(o_iss_prd), 32'(m_iss.prd));
        chk("iss_pred_taken", 32'(o_iss_pred_taken), 32'(m_iss.pt));
        chk("iss_pred_target", o_iss_pred_target, m_iss.ptgt);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        i_disp_valid = 0; i_cdb_valid = 0; i_flush = 0;
    endtask

    task automatic set_disp(logic [3:0] op, logic [31:0] pc, logic [3:0] tag, logic [6:0] s1,
                            logic [6:0] s2, logic r1, logic r2, logic [31:0] v1, logic [31:0] v2);
        i_disp_valid = 1; i_disp_alu_op = op; i_disp_pc = pc; i_disp_imm = pc ^ 32'h55;
        i_disp_rob_tag = tag; i_disp_prd = 7'(tag) + 7'd64; i_disp_prs1 = s1; i_disp_prs2 = s2;
        i_disp_rdy1 = r1; i_disp_rdy2 = r2; i_disp_val1 = v1; i_disp_val2 = v2;
        i_disp_pred_taken = pc[4]; i_disp_pred_target = pc + 32'h40;
    endtask

    task automatic set_cdb(logic [6:0] prd, logic [31:0] data);
        i_cdb_valid = 1; i_cdb_prd = prd; i_cdb_data = data;
    endtask

    // Asynchronous reset asserted mid-cycle: outputs must clear without waiting for an edge.
    task automatic do_reset();
        idle();
        i_rst_n = 0;
        m_reset();
        #1;
        chk("rst_disp_ready", 32'(o_disp_ready), 32'd1);
        chk("rst_iss_valid", 32'(o_iss_valid), 32'd0);
        chk("rst_iss_op1", o_iss_op1, 32'd0);
        chk("rst_iss_pc", o_iss_pc, 32'd0);
        chk("rst_iss_tag", 32'(o_iss_rob_tag), 32'd0);
        @(posedge clk);
        #2;
        i_rst_n = 1;
    endtask

    initial begin
        i_rst_n = 0; i_rob_head = 0; i_flush_rob_tag = 0;
        i_cdb_prd = 0; i_cdb_data = 0;
        set_disp(4'd0, 32'd0, 4'd0, 7'd0, 7'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        idle();
        #12;
        do_reset();

        // BEQ ready at dispatch: valid after the second edge, for one cycle
        set_disp(4'd0, 32'h100, 4'd1, 7'd1, 7'd2, 1'b1, 1'b1, 32'd5, 32'd5);
        step();
        chk("beq_not_yet", 32'(o_iss_valid), 32'd0);
        idle();
        step();
        chk("beq_valid", 32'(o_iss_valid), 32'd1);
        chk("beq_op1", o_iss_op1, 32'd5);
        chk("beq_op2", o_iss_op2, 32'd5);
        chk("beq_pc", o_iss_pc, 32'h100);
        step();
        chk("beq_low", 32'(o_iss_valid), 32'd0);

        // BNE woken by CDB two cycles after dispatch
        set_disp(4'd1, 32'h200, 4'd2, 7'd12, 7'd3, 1'b0, 1'b1, 32'd0, 32'd9);
        step();
        idle();
        step();
        set_cdb(7'd12, 32'h7);
        step();
        chk("bne_wait", 32'(o_iss_valid), 32'd0);
        idle();
        step();
        chk("bne_valid", 32'(o_iss_valid), 32'd1);
        chk("bne_op1", o_iss_op1, 32'h7);
        chk("bne_op2", o_iss_op2, 32'd9);

        // Fill, then wake the middle entry
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_disp(4'(k), 32'h300 + 32'(k * 4), 4'(4 + k), 7'(20 + k), 7'd0, 1'b0, 1'b1, 32'd0, 32'd1);
            step();
        end
        chk("full_ready", 32'(o_disp_ready), 32'd0);
        set_disp(4'd5, 32'h3f0, 4'd9, 7'd1, 7'd1, 1'b1, 1'b1, 32'd1, 32'd1);
        i_disp_valid = 1;
        set_cdb(7'd22, 32'h33);
        step();
        idle();
        step();
        chk("mid_valid", 32'(o_iss_valid), 32'd1);
        chk("mid_tag", 32'(o_iss_rob_tag), 32'd6);
        chk("mid_op1", o_iss_op1, 32'h33);
        chk("mid_ready", 32'(o_disp_ready), 32'd1);
        set_cdb(7'd23, 32'h44);
        step();
        idle();
        step();
        chk("shift_tag", 32'(o_iss_rob_tag), 32'd7);

        // Flush younger than tag 4 with head 2; same-cycle dispatch dropped
        do_reset();
        i_rob_head = 4'd2;
        for (int k = 0; k < 4; k++) begin
            set_disp(4'd4, 32'h400 + 32'(k * 4), 4'(3 + k), 7'd40, 7'd0, 1'b0, 1'b1, 32'd0, 32'd2);
            step();
        end
        set_disp(4'd6, 32'h4f0, 4'd9, 7'd1, 7'd1, 1'b1, 1'b1, 32'd1, 32'd1);
        i_flush = 1; i_flush_rob_tag = 4'd4;
        step();
        idle();
        chk("flush_ready", 32'(o_disp_ready), 32'd1);
        set_cdb(7'd40, 32'h99);
        step();
        idle();
        step();
        chk("flush_iss3", 32'(o_iss_rob_tag), 32'd3);
        step();
        chk("flush_iss4", 32'(o_iss_rob_tag), 32'd4);
        step();
        chk("flush_empty", 32'(o_iss_valid), 32'd0);

        // Wrap-around age: head 14, flush tag 15 keeps 15, drops 0 and 1
        do_reset();
        i_rob_head = 4'd14;
        for (int k = 0; k < 3; k++) begin
            set_disp(4'd5, 32'h500 + 32'(k * 4), 4'((15 + k) % 16), 7'd50, 7'd0, 1'b0, 1'b1, 32'd0, 32'd3);
            step();
        end
        idle();
        i_flush = 1; i_flush_rob_tag = 4'd15;
        step();
        idle();
        set_cdb(7'd50, 32'h5);
        step();
        idle();
        step();
        chk("wrap_tag", 32'(o_iss_rob_tag), 32'd15);
        step();
        chk("wrap_empty", 32'(o_iss_valid), 32'd0);

        // Older entry blocked, younger entry ready
        do_reset();
        set_disp(4'd0, 32'h600, 4'd1, 7'd60, 7'd0, 1'b0, 1'b1, 32'd0, 32'd0);
        step();
        set_disp(4'd1, 32'h604, 4'd2, 7'd0, 7'd0, 1'b1, 1'b1, 32'd8, 32'd8);
        step();
        idle();
        step();
`ifdef BRANCH_RS_INORDER_EN
        chk("order_block", 32'(o_iss_valid), 32'd0);
`else
        chk("order_bypass", 32'(o_iss_valid), 32'd1);
`endif
        set_cdb(7'd60, 32'h61);
        step();
        idle();
        repeat (3) step();

        // Random traffic with occasional mid-run reset
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            i_disp_valid = ($urandom % 100) < 60;
            i_disp_alu_op = 4'($urandom_range(0, 9));
            i_disp_pc = $urandom; i_disp_imm = $urandom;
            i_disp_rob_tag = 4'($urandom); i_disp_prd = 7'($urandom);
            i_disp_prs1 = 7'($urandom % 8); i_disp_prs2 = 7'($urandom % 8);
            i_disp_rdy1 = 1'($urandom); i_disp_rdy2 = 1'($urandom);
            i_disp_val1 = $urandom; i_disp_val2 = $urandom;
            i_disp_pred_taken = 1'($urandom); i_disp_pred_target = $urandom;
            i_cdb_valid = ($urandom % 100) < 40;
            i_cdb_prd = 7'($urandom % 8); i_cdb_data = $urandom;
            i_flush = ($urandom % 100) < 6;
            i_flush_rob_tag = 4'($urandom);
            if ($urandom % 16 == 0) i_rob_head = 4'($urandom);
            if (c % 700 == 350) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
